// File: rtl/lutram_bist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lutram_bist_pkg : state encoding, pattern modes and pattern generator.     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package lutram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] PAT_ADDR_LSB   = 2'd0;
  localparam logic [1:0] PAT_ADDR_LSB_N = 2'd1;
  localparam logic [1:0] PAT_ADDR       = 2'd2;
  localparam logic [1:0] PAT_ADDR_N     = 2'd3;

  // Patterns are built at this width and truncated by the caller to D_WIDTH.
  localparam int PAT_W = 32;

  function automatic logic [PAT_W-1:0] pat(input logic [1:0] mode,
                                           input logic [PAT_W-1:0] addr);
    logic [PAT_W-1:0] r;
    case (mode)
      PAT_ADDR_LSB:   r = {PAT_W{addr[0]}};
      PAT_ADDR_LSB_N: r = ~{PAT_W{addr[0]}};
      PAT_ADDR:       r = addr;
      default:        r = ~addr;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lutram_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lutram_dp : dual-port distributed RAM, synchronous write, async SPO/DPO.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module lutram_dp #(
  parameter int A_WIDTH = 6,
  parameter int D_WIDTH = 1
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [D_WIDTH-1:0] i_d,
  input  logic [A_WIDTH-1:0] i_dpra,
  output logic [D_WIDTH-1:0] o_spo,
  output logic [D_WIDTH-1:0] o_dpo
);

  // One column per data bit, each a 2**A_WIDTH x 1 dual-port LUT RAM.
  genvar b;
  generate
    for (b = 0; b < D_WIDTH; b++) begin : g_bit
      logic r_mem [2**A_WIDTH];

      always_ff @(posedge i_clk) begin
        if (i_we) begin
          r_mem[i_a] <= i_d[b];
        end
      end

      assign o_spo[b] = r_mem[i_a];
      assign o_dpo[b] = r_mem[i_dpra];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/lutram_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lutram_bist : clear / write pattern / dual-port read-check BIST for LUTRAM.|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module lutram_bist
  import lutram_bist_pkg::*;
#(
  parameter int          A_WIDTH  = 6,
  parameter int          D_WIDTH  = 1,
  parameter logic [31:0] TICK_DIV = 32'h00FF_FFFF,
  parameter int          ECW      = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic                   inj_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ECW-1:0]         err_count_o,
  output logic [A_WIDTH-1:0]     first_err_addr_o,
  output logic [2*D_WIDTH-1:0]   q_o
);

  localparam logic [A_WIDTH-1:0] c_last     = '1;
  localparam logic [A_WIDTH-1:0] c_inj_addr = A_WIDTH'(2**(A_WIDTH-1));

  state_t               r_state, w_state_nxt;
  logic [A_WIDTH-1:0]   r_addr;
  logic [31:0]          r_tick;
  logic [1:0]           r_mode;
  logic                 r_inj;
  logic                 r_busy, r_done, r_pass, r_first_seen;
  logic [ECW-1:0]       r_err;
  logic [A_WIDTH-1:0]   r_first;

  logic                 w_active, w_tick, w_last, w_start, w_we;
  logic [A_WIDTH-1:0]   w_naddr;
  logic [D_WIDTH-1:0]   w_pat_s, w_pat_d, w_wdata, w_spo, w_dpo;
  logic                 w_mis_s, w_mis_d;
  logic [1:0]           w_inc;
  logic [ECW:0]         w_sum;
  logic [ECW-1:0]       w_err_nxt;

  assign w_active = (r_state == S_CLEAR) || (r_state == S_WRITE) || (r_state == S_READ);
  assign w_tick   = w_active && (r_tick == TICK_DIV - 32'd1);
  assign w_last   = (r_addr == c_last);
  assign w_start  = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_naddr  = ~r_addr;

  assign w_pat_s  = D_WIDTH'(pat(r_mode, PAT_W'(r_addr)));
  assign w_pat_d  = D_WIDTH'(pat(r_mode, PAT_W'(w_naddr)));

  // Injected fault flips bit 0 of the mid-array word during WRITE only.
  assign w_wdata  = (r_state == S_CLEAR) ? '0 :
                    (r_inj && (r_addr == c_inj_addr)) ? (w_pat_s ^ D_WIDTH'(1)) : w_pat_s;
  assign w_we     = w_tick && ((r_state == S_CLEAR) || (r_state == S_WRITE));

  lutram_dp #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .i_clk  (clk_i),
    .i_we   (w_we),
    .i_a    (r_addr),
    .i_d    (w_wdata),
    .i_dpra (w_naddr),
    .o_spo  (w_spo),
    .o_dpo  (w_dpo)
  );

  assign w_mis_s   = (w_spo != w_pat_s);
  assign w_mis_d   = (w_dpo != w_pat_d);
  assign w_inc     = {1'b0, w_mis_s} + {1'b0, w_mis_d};
  assign w_sum     = {1'b0, r_err} + (ECW+1)'(w_inc);
  assign w_err_nxt = w_sum[ECW] ? '1 : w_sum[ECW-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start_i)          w_state_nxt = S_CLEAR;
      S_CLEAR:        if (w_tick && w_last) w_state_nxt = S_WRITE;
      S_WRITE:        if (w_tick && w_last) w_state_nxt = S_READ;
      S_READ:         if (w_tick && w_last) w_state_nxt = S_DONE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr       <= '0;
      r_tick       <= '0;
      r_mode       <= PAT_ADDR_LSB;
      r_inj        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_first      <= '0;
      r_first_seen <= 1'b0;
    end else if (w_start) begin
      r_mode       <= mode_i;
      r_inj        <= inj_i;
      r_addr       <= '0;
      r_tick       <= '0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_first      <= '0;
      r_first_seen <= 1'b0;
    end else if (w_active) begin
      if (w_tick) begin
        r_tick <= '0;
        r_addr <= r_addr + 1'b1;
      end else begin
        r_tick <= r_tick + 32'd1;
      end
      if (w_tick && (r_state == S_READ)) begin
        r_err <= w_err_nxt;
        if ((w_inc != 2'd0) && !r_first_seen) begin
          r_first      <= r_addr;
          r_first_seen <= 1'b1;
        end
        // Final step's result must be folded into the verdict on the same edge.
        if (w_last) begin
          r_done <= 1'b1;
          r_pass <= (w_err_nxt == '0);
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign err_count_o      = r_err;
  assign first_err_addr_o = r_first;
  assign q_o              = {w_dpo, w_spo};

endmodule
`default_nettype wire

// File: tb/tb_lutram_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lutram_bist : scoreboard bench over three lutram_bist configurations.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_lutram_bist;

  typedef struct {
    int err;
    int first;
    bit pass;
    int cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] st  = 3'b000;
  logic [1:0] mode_s = 2'd0;
  logic       inj_s  = 1'b0;

  logic       busy0, done0, pass0;
  logic [7:0] err0;
  logic [5:0] first0;
  logic [1:0] q0;
  logic       busy1, done1, pass1;
  logic [7:0] err1;
  logic [3:0] first1;
  logic [7:0] q1;
  logic       busy2, done2, pass2;
  logic [1:0] err2;
  logic [5:0] first2;
  logic [1:0] q2;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  lutram_bist #(.A_WIDTH(6), .D_WIDTH(1), .TICK_DIV(32'd1), .ECW(8)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(st[0]), .mode_i(mode_s), .inj_i(inj_s),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_count_o(err0),
    .first_err_addr_o(first0), .q_o(q0));

  lutram_bist #(.A_WIDTH(4), .D_WIDTH(4), .TICK_DIV(32'd1), .ECW(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(st[1]), .mode_i(mode_s), .inj_i(inj_s),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
    .first_err_addr_o(first1), .q_o(q1));

  lutram_bist #(.A_WIDTH(6), .D_WIDTH(1), .TICK_DIV(32'd1), .ECW(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(st[2]), .mode_i(mode_s), .inj_i(inj_s),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
    .first_err_addr_o(first2), .q_o(q2));

  function automatic int pat_m(int mode, int a, int dw);
    int dm = (1 << dw) - 1;
    case (mode)
      0:       return (a & 1) ? dm : 0;
      1:       return (a & 1) ? 0 : dm;
      2:       return a & dm;
      default: return (~a) & dm;
    endcase
  endfunction

  // Reference: what a correct RAM would hold, then both-port read-check.
  function automatic exp_t model(int aw, int dw, int mode, int inj, int stuck, int ecw);
    exp_t r;
    int   mem[64];
    int   depth = 1 << aw;
    bit   seen = 0;
    r.err = 0; r.first = 0;
    for (int a = 0; a < depth; a++) begin
      mem[a] = pat_m(mode, a, dw);
      if (inj != 0 && a == depth / 2) mem[a] = mem[a] ^ 1;
      if (stuck != 0) mem[a] = 0;
    end
    for (int a = 0; a < depth; a++) begin
      int na = (~a) & (depth - 1);
      int e  = ((mem[a] != pat_m(mode, a, dw)) ? 1 : 0) + ((mem[na] != pat_m(mode, na, dw)) ? 1 : 0);
      r.err += e;
      if (e != 0 && !seen) begin r.first = a; seen = 1; end
    end
    if (r.err > (1 << ecw) - 1) r.err = (1 << ecw) - 1;
    r.pass   = (r.err == 0);
    r.cycles = 1 + 3 * depth;
    return r;
  endfunction

  task automatic sample(input int sel, output bit b, output bit d, output bit p,
                        output int e, output int f);
    case (sel)
      0:       begin b = busy0; d = done0; p = pass0; e = int'(err0); f = int'(first0); end
      1:       begin b = busy1; d = done1; p = pass1; e = int'(err1); f = int'(first1); end
      default: begin b = busy2; d = done2; p = pass2; e = int'(err2); f = int'(first2); end
    endcase
  endtask

  // Starts one DUT and waits (bounded) for done; reports observed latencies.
  task automatic run(input int sel, input int mode, input int inj, input bit toggle,
                     output int busy_lat, output int done_lat, output bit done_dropped,
                     output bit busy_at_done, output bit p, output int e, output int f);
    bit b, d;
    busy_lat = -1; done_lat = -1; done_dropped = 0; busy_at_done = 1; p = 0; e = -1; f = -1;
    @(negedge clk);
    mode_s  = 2'(mode);
    inj_s   = (inj != 0);
    st[sel] = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk); #1;
      sample(sel, b, d, p, e, f);
      if (c == 1) begin st[sel] = 1'b0; done_dropped = !d; end
      if (b && busy_lat < 0) busy_lat = c;
      if (toggle && c > 140 && c < 180) st[sel] = ((c % 2) == 1);
      if (d) begin done_lat = c; busy_at_done = b; break; end
    end
    st[sel] = 1'b0;
  endtask

  task automatic test_reset;
    bit b, d, p; int e, f;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 sample(0, b, d, p, e, f);
    tests++; if (b !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0d want 0", b); end
    tests++; if (d !== 1'b0) begin fails++; $display("FAIL reset_done: got %0d want 0", d); end
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL reset_pass: got %0d want 0", p); end
    tests++; if (e !== 0)    begin fails++; $display("FAIL reset_err: got %0d want 0", e); end
    tests++; if (f !== 0)    begin fails++; $display("FAIL reset_first: got %0d want 0", f); end
  endtask

  task automatic test_mode0;
    exp_t x; int bl, dl, e, f; bit dd, bd, p; int qe;
    sb.push_back(model(6, 1, 0, 0, 0, 8));
    run(0, 0, 0, 0, bl, dl, dd, bd, p, e, f);
    x  = sb.pop_front();
    qe = (pat_m(0, 63, 1) << 1) | pat_m(0, 0, 1);
    tests++; if (bl !== 1)        begin fails++; $display("FAIL m0_busy_lat: got %0d want 1", bl); end
    tests++; if (dl !== x.cycles) begin fails++; $display("FAIL m0_done_lat: got %0d want %0d", dl, x.cycles); end
    tests++; if (bd !== 1'b0)     begin fails++; $display("FAIL m0_busy_at_done: got %0d want 0", bd); end
    tests++; if (p !== x.pass)    begin fails++; $display("FAIL m0_pass: got %0d want %0d", p, x.pass); end
    tests++; if (e !== x.err)     begin fails++; $display("FAIL m0_err: got %0d want %0d", e, x.err); end
    tests++; if (int'(q0) !== qe) begin fails++; $display("FAIL m0_q: got %0d want %0d", q0, qe); end
  endtask

  task automatic test_inject;
    exp_t x; int bl, dl, e, f; bit dd, bd, p;
    sb.push_back(model(6, 1, 1, 1, 0, 8));
    run(0, 1, 1, 0, bl, dl, dd, bd, p, e, f);
    x = sb.pop_front();
    tests++; if (e !== x.err)     begin fails++; $display("FAIL inj_err: got %0d want %0d", e, x.err); end
    tests++; if (f !== x.first)   begin fails++; $display("FAIL inj_first: got %0d want %0d", f, x.first); end
    tests++; if (p !== x.pass)    begin fails++; $display("FAIL inj_pass: got %0d want %0d", p, x.pass); end
    tests++; if (dl !== x.cycles) begin fails++; $display("FAIL inj_done_lat: got %0d want %0d", dl, x.cycles); end
  endtask

  task automatic test_back_to_back;
    exp_t x; int bl, dl, e, f; bit dd, bd, p;
    for (int m = 2; m <= 3; m++) begin
      sb.push_back(model(4, 4, m, 0, 0, 8));
      run(1, m, 0, 0, bl, dl, dd, bd, p, e, f);
      x = sb.pop_front();
      tests++; if (dl !== x.cycles) begin fails++; $display("FAIL b2b_done_lat m%0d: got %0d want %0d", m, dl, x.cycles); end
      tests++; if (p !== x.pass)    begin fails++; $display("FAIL b2b_pass m%0d: got %0d want %0d", m, p, x.pass); end
      tests++; if (e !== x.err)     begin fails++; $display("FAIL b2b_err m%0d: got %0d want %0d", m, e, x.err); end
      if (m == 3) begin
        tests++; if (dd !== 1'b1) begin fails++; $display("FAIL b2b_done_drop: got %0d want 1", dd); end
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t x; int bl, dl, e, f; bit dd, bd, p, b, d;
    @(negedge clk);
    mode_s = 2'd0; inj_s = 1'b0; st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (74) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    sample(0, b, d, p, e, f);
    rst = 1'b0;
    tests++; if (b !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %0d want 0", b); end
    tests++; if (e !== 0 || f !== 0 || d !== 1'b0 || p !== 1'b0) begin
      fails++; $display("FAIL mid_rst_outs: got err=%0d first=%0d done=%0d pass=%0d want all 0", e, f, d, p);
    end
    sb.push_back(model(6, 1, 0, 0, 0, 8));
    run(0, 0, 0, 0, bl, dl, dd, bd, p, e, f);
    x = sb.pop_front();
    tests++; if (dl !== x.cycles) begin fails++; $display("FAIL mid_rerun_lat: got %0d want %0d", dl, x.cycles); end
    tests++; if (p !== x.pass)    begin fails++; $display("FAIL mid_rerun_pass: got %0d want %0d", p, x.pass); end
  endtask

  task automatic test_saturate;
    exp_t x; int bl, dl, e, f; bit dd, bd, p;
    force dut2.w_spo = 1'b0;
    force dut2.w_dpo = 1'b0;
    sb.push_back(model(6, 1, 1, 0, 1, 2));
    run(2, 1, 0, 0, bl, dl, dd, bd, p, e, f);
    x = sb.pop_front();
    release dut2.w_spo;
    release dut2.w_dpo;
    tests++; if (e !== x.err)   begin fails++; $display("FAIL sat_err: got %0d want %0d", e, x.err); end
    tests++; if (f !== x.first) begin fails++; $display("FAIL sat_first: got %0d want %0d", f, x.first); end
    tests++; if (p !== x.pass)  begin fails++; $display("FAIL sat_pass: got %0d want %0d", p, x.pass); end
  endtask

  task automatic test_start_ignored;
    exp_t x; int bl, dl, e, f; bit dd, bd, p;
    sb.push_back(model(6, 1, 3, 0, 0, 8));
    run(0, 3, 0, 1, bl, dl, dd, bd, p, e, f);
    x = sb.pop_front();
    tests++; if (dl !== x.cycles) begin fails++; $display("FAIL ign_done_lat: got %0d want %0d", dl, x.cycles); end
    tests++; if (p !== x.pass)    begin fails++; $display("FAIL ign_pass: got %0d want %0d", p, x.pass); end
    tests++; if (e !== x.err)     begin fails++; $display("FAIL ign_err: got %0d want %0d", e, x.err); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_inject();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
